// File: rtl/iobs_pkg.sv
// iobs_pkg: shared state encoding and E-clock timing constants for the IOBS
// fast-bus to Mac-bus bridge.
package iobs_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      AS    = 3'd1,
      DS    = 3'd2,
      WAIT  = 3'd3,
      VWAIT = 3'd4,
      LATCH = 3'd5,
      END   = 3'd6,
      REL   = 3'd7
   } iobsState_t;

   localparam int ECNT_W = 5;

   // Last count of the 20-cycle E period, first E-high count, and the count
   // a VPA cycle must pass before it may finish on the E-high phase.
   localparam logic [ECNT_W-1:0] ECNT_MAX = 5'd19;
   localparam logic [ECNT_W-1:0] E_RISE   = 5'd12;
   localparam logic [ECNT_W-1:0] VPA_SYNC = 5'd11;

   // Next value of the E divider count, wrapping after ECNT_MAX.
   function automatic logic [ECNT_W-1:0] ecntNext(input logic [ECNT_W-1:0] cnt);
      return (cnt == ECNT_MAX) ? '0 : cnt + 5'd1;
   endfunction

endpackage

// File: rtl/iobs_if.sv
// iobs_if: fast-bus request/handshake and Mac-bus strobe signals of the IOBS
// bridge. The slave modport is the bridge itself, the master modport is the
// environment (fast-bus requester plus Mac-bus peripheral).
interface iobs_if;

   logic IOREQ;
   logic IORW;
   logic IOL;
   logic IOU;
   logic IOACTV;
   logic IOBERR;
   logic nASout;
   logic nLDSout;
   logic nUDSout;
   logic nWEout;
   logic nDoutOE;
   logic nDinLE;
   logic nDTACKin;
   logic nVPAin;
   logic nBERRin;
   logic E;

   modport slave (
      input  IOREQ, IORW, IOL, IOU, nDTACKin, nVPAin, nBERRin,
      output IOACTV, IOBERR, nASout, nLDSout, nUDSout, nWEout,
             nDoutOE, nDinLE, E
   );

   modport master (
      output IOREQ, IORW, IOL, IOU, nDTACKin, nVPAin, nBERRin,
      input  IOACTV, IOBERR, nASout, nLDSout, nUDSout, nWEout,
             nDoutOE, nDinLE, E
   );

endinterface

// File: rtl/iobs_eclk.sv
// iobs_eclk: free-running 6800 E clock generator. Divides the bus clock by 20
// and drives E high for counts 12..19. Only built when IOBS_ECLK_EN is defined.
module iobs_eclk
   import iobs_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_nRes,
   output logic [ECNT_W-1:0] o_ecnt,
   output logic              o_e
);

   logic [ECNT_W-1:0] r_ecnt;
   logic              r_e;
   logic [ECNT_W-1:0] w_ecntNext;

   assign w_ecntNext = ecntNext(r_ecnt);

   // Advance the divider every cycle and register E so it never glitches.
   always_ff @(posedge i_clk) begin
      if (!i_nRes) begin
         r_ecnt <= '0;
         r_e    <= 1'b0;
      end else begin
         r_ecnt <= w_ecntNext;
         r_e    <= (w_ecntNext >= E_RISE);
      end
   end

   assign o_ecnt = r_ecnt;
   assign o_e    = r_e;

endmodule

// File: rtl/iobs.sv
// iobs: runs one 68000-style Mac bus cycle for each fast-bus IOREQ.
// Define IOBS_ECLK_EN to add the E clock and VPA (6800-synchronous) cycles;
// without it E is tied low and VPA completes a cycle exactly like DTACK.
module iobs
   import iobs_pkg::*;
(
   input logic   CLK,
   input logic   nRES,
   iobs_if.slave bus
);

   logic       r_ioreqMeta;
   logic       r_ioreqR;
   logic       r_dtackR;
   logic       r_vpaR;
   logic       r_berrR;

   iobsState_t r_state;
   iobsState_t w_stateNext;

   logic       r_ioactv;
   logic       r_ioberr;
   logic       r_nAs;
   logic       r_nLds;
   logic       r_nUds;
   logic       r_nWe;
   logic       r_nDoutOe;
   logic       r_nDinLe;

   logic       w_ioactvNext;
   logic       w_ioberrNext;
   logic       w_nAsNext;
   logic       w_nLdsNext;
   logic       w_nUdsNext;
   logic       w_nWeNext;
   logic       w_nDoutOeNext;
   logic       w_nDinLeNext;

`ifdef IOBS_ECLK_EN
   logic [ECNT_W-1:0] w_ecnt;
   logic              w_e;
   logic              r_vSeen;

   iobs_eclk u_eclk (
      .i_clk  (CLK),
      .i_nRes (nRES),
      .o_ecnt (w_ecnt),
      .o_e    (w_e)
   );

   assign bus.E = w_e;

   // A VPA cycle may only finish at the end of an E-high phase it fully saw,
   // so remember that count VPA_SYNC went by while waiting.
   always_ff @(posedge CLK) begin
      if (!nRES)
         r_vSeen <= 1'b0;
      else if (r_state != VWAIT)
         r_vSeen <= 1'b0;
      else if (w_ecnt == VPA_SYNC)
         r_vSeen <= 1'b1;
   end
`else
   assign bus.E = 1'b0;
`endif

   // IOREQ is asynchronous to CLK and gets two flops; the Mac-bus replies are
   // registered once and kept in active-high form.
   always_ff @(posedge CLK) begin
      if (!nRES) begin
         r_ioreqMeta <= 1'b0;
         r_ioreqR    <= 1'b0;
         r_dtackR    <= 1'b0;
         r_vpaR      <= 1'b0;
         r_berrR     <= 1'b0;
      end else begin
         r_ioreqMeta <= bus.IOREQ;
         r_ioreqR    <= r_ioreqMeta;
         r_dtackR    <= ~bus.nDTACKin;
         r_vpaR      <= ~bus.nVPAin;
         r_berrR     <= ~bus.nBERRin;
      end
   end

   // State and bus-output registers; reset drops every strobe at once, so an
   // access in flight is abandoned without an END phase.
   always_ff @(posedge CLK) begin
      if (!nRES) begin
         r_state   <= IDLE;
         r_ioactv  <= 1'b0;
         r_ioberr  <= 1'b0;
         r_nAs     <= 1'b1;
         r_nLds    <= 1'b1;
         r_nUds    <= 1'b1;
         r_nWe     <= 1'b1;
         r_nDoutOe <= 1'b1;
         r_nDinLe  <= 1'b1;
      end else begin
         r_state   <= w_stateNext;
         r_ioactv  <= w_ioactvNext;
         r_ioberr  <= w_ioberrNext;
         r_nAs     <= w_nAsNext;
         r_nLds    <= w_nLdsNext;
         r_nUds    <= w_nUdsNext;
         r_nWe     <= w_nWeNext;
         r_nDoutOe <= w_nDoutOeNext;
         r_nDinLe  <= w_nDinLeNext;
      end
   end

   // Sequence through the Mac bus cycle; bus error outranks DTACK, and a
   // request still held after completion is parked in REL until it drops.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:  if (r_ioreqR) w_stateNext = AS;
         AS:    w_stateNext = DS;
         DS:    w_stateNext = WAIT;
         WAIT: begin
            if (r_berrR)
               w_stateNext = END;
            else if (r_dtackR)
               w_stateNext = LATCH;
`ifdef IOBS_ECLK_EN
            else if (r_vpaR)
               w_stateNext = VWAIT;
`else
            else if (r_vpaR)
               w_stateNext = LATCH;
`endif
         end
`ifdef IOBS_ECLK_EN
         VWAIT: begin
            if (r_berrR)
               w_stateNext = END;
            else if (r_vSeen && (w_ecnt == ECNT_MAX))
               w_stateNext = LATCH;
         end
`endif
         LATCH: w_stateNext = END;
         END:   w_stateNext = REL;
         REL:   if (!r_ioreqR) w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // Compute what each bus output becomes on the edge that leaves the current
   // state; reads drive the lane strobes with AS, writes one cycle later.
   always_comb begin
      w_ioactvNext  = r_ioactv;
      w_ioberrNext  = r_ioberr;
      w_nAsNext     = r_nAs;
      w_nLdsNext    = r_nLds;
      w_nUdsNext    = r_nUds;
      w_nWeNext     = r_nWe;
      w_nDoutOeNext = r_nDoutOe;
      w_nDinLeNext  = r_nDinLe;
      case (r_state)
         IDLE: begin
            if (r_ioreqR)
               w_ioactvNext = 1'b1;
         end
         AS: begin
            w_nAsNext    = 1'b0;
            w_nWeNext    = bus.IORW;
            w_ioberrNext = 1'b0;
            if (bus.IORW) begin
               w_nLdsNext = ~bus.IOL;
               w_nUdsNext = ~bus.IOU;
            end else begin
               w_nDoutOeNext = 1'b0;
            end
         end
         DS: begin
            if (!r_nWe) begin
               w_nLdsNext = ~bus.IOL;
               w_nUdsNext = ~bus.IOU;
            end
         end
         WAIT: begin
            if (r_berrR)
               w_ioberrNext = 1'b1;
         end
`ifdef IOBS_ECLK_EN
         VWAIT: begin
            if (r_berrR)
               w_ioberrNext = 1'b1;
         end
`endif
         LATCH: begin
            if (r_nWe)
               w_nDinLeNext = 1'b0;
         end
         END: begin
            w_nAsNext     = 1'b1;
            w_nLdsNext    = 1'b1;
            w_nUdsNext    = 1'b1;
            w_nDoutOeNext = 1'b1;
            w_nDinLeNext  = 1'b1;
            w_nWeNext     = 1'b1;
            w_ioactvNext  = 1'b0;
         end
         default: begin
         end
      endcase
   end

   assign bus.IOACTV  = r_ioactv;
   assign bus.IOBERR  = r_ioberr;
   assign bus.nASout  = r_nAs;
   assign bus.nLDSout = r_nLds;
   assign bus.nUDSout = r_nUds;
   assign bus.nWEout  = r_nWe;
   assign bus.nDoutOE = r_nDoutOe;
   assign bus.nDinLE  = r_nDinLe;

endmodule

// File: doc/iobs.md
IOBS -- requirements
Module: iobs

Interface
REQ-001 SHALL have one clock and one reset: the clock is CLK, and the reset is nRES, synchronous and active-low.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK  in  1  16 MHz IO-bus clock.
- nRES  in  1  synchronous active-low reset.
- IOREQ  in  1  access request from fast bus; asynchronous.
- IORW  in  1  1 = read, 0 = write; stable while IOREQ is high.
- IOL  in  1  low-byte lane requested.
- IOU  in  1  high-byte lane requested.
- IOACTV  out  1  access in progress, back to fast bus.
- IOBERR  out  1  Mac-side bus error seen on the current access.
- nASout  out  1  Mac bus address strobe.
- nLDSout  out  1  Mac bus low data strobe.
- nUDSout  out  1  Mac bus high data strobe.
- nWEout  out  1  Mac bus R/W; 0 = write.
- nDoutOE  out  1  drive write data onto the Mac bus.
- nDinLE  out  1  latch read data from the Mac bus; transparent while low.
- nDTACKin  in  1  Mac bus DTACK.
- nVPAin  in  1  Mac bus VPA.
- nBERRin  in  1  Mac bus BERR.
- E  out  1  6800 E clock.

Function
REQ-003 IOREQ SHALL pass through a two-flop synchronizer (IOREQr); no other input is synchronized, and Mac inputs are registered once (DTACKr, VPAr, BERRr).
REQ-004 The state machine SHALL have these states: IDLE, AS, DS, WAIT, VWAIT, LATCH, END, REL.
REQ-005 IDLE: when IOREQr=1, go to AS and set IOACTV<=1 on the same edge; otherwise stay.
REQ-006 AS: nASout<=0, nWEout<=IORW, IOBERR<=0; on a read also assert nLDSout=~IOL and nUDSout=~IOU; on a write nDoutOE<=0; go to DS.
REQ-007 DS: on a write assert the lane strobes as in REQ-006; go to WAIT.
REQ-008 WAIT, checked in priority order: BERRr -> IOBERR<=1, go to END; DTACKr -> LATCH; VPAr -> VWAIT (ECLK_EN only, see REQ-013); otherwise stay, with no timeout.
REQ-009 LATCH: on a read, nDinLE<=0 for exactly one cycle; go to END.
REQ-010 END: negate nASout, nLDSout, nUDSout, nDoutOE and nDinLE; set nWEout<=1 and IOACTV<=0; go to REL.
REQ-011 REL: stay until IOREQr=0, then go to IDLE; a request still held high after completion SHALL NOT start a second access.
REQ-012 IOACTV SHALL be high from the edge leaving IDLE through the edge entering REL, and never high in IDLE or REL.
REQ-013 E divider: a 5-bit counter ECNT counts 0..19 and wraps; E=1 for ECNT 12..19 (8 of 20 cycles high); it runs freely regardless of bus state.
REQ-014 VWAIT: wait for ECNT==11, then hold through E-high; at ECNT==19 go to LATCH; BERRr during VWAIT goes to END with IOBERR=1.
REQ-015 Simultaneous BERRr and DTACKr SHALL be treated as a bus error: no latch pulse, IOBERR=1.
REQ-016 IOBERR SHALL hold its value from END until the next AS.

Reset
REQ-017 While nRES=0 at a CLK edge, outputs SHALL be: state=IDLE, IOACTV=0, IOBERR=0, all Mac strobes, nWEout, nDoutOE and nDinLE =1, ECNT=0, E=0, synchronizer flops=0.
REQ-018 Reset mid-access SHALL abort immediately with no END sequencing; strobes are negated on the reset edge.

Configuration
REQ-019 With macro IOBS_ECLK_EN defined, the E generator and VWAIT SHALL be present.
REQ-020 With IOBS_ECLK_EN undefined, E SHALL be tied 0, VWAIT SHALL be absent, and VPAr in WAIT SHALL be treated as DTACKr.

Structure
REQ-021 Package iobs_pkg SHALL hold the state enum, ECNT_MAX=19, E_RISE=12 and VPA_SYNC=11.
REQ-022 The E divider SHALL be sub-module iobs_eclk, instantiated only under IOBS_ECLK_EN.

Verification
REQ-023 Read: IOREQ=1, IORW=1, IOL=IOU=1, DTACK low 3 cycles after nASout falls -> one nDinLE low pulse, IOACTV high 7 cycles, then REL.
REQ-024 Write, IOU only: nUDSout falls one cycle after nASout, nLDSout stays 1, nDoutOE=0 from AS through END, no nDinLE pulse.
REQ-025 BERR and DTACK low on the same edge -> IOBERR=1, no nDinLE pulse, IOACTV falls next cycle.
REQ-026 IOREQ held high 50 cycles after completion -> exactly one access; IOREQ low then high -> second access starts.
REQ-027 VPA cycle with ECLK_EN, VPA sampled at ECNT=3 -> nDinLE pulse at ECNT=0 after wrap; without ECLK_EN -> behaves as a DTACK cycle.
REQ-028 nRES low during WAIT -> all strobes 1 and IOACTV=0 on that edge; a new IOREQ after reset runs a normal cycle.
